serial_eq_cmp: RTL and testbench
================================

# serial_eq_cmp

Serial N-bit equality comparator that sits directly downstream of the 1-bit equality stage. It consumes two LSB-first bit streams one bit pair per accepted cycle and applies the single-bit equality function (out = ~(b1 ^ b2)) to each pair. It accumulates the per-bit results across an N-bit word and reports a registered word-equal flag plus the index of the first mismatching bit. It forms the word-level wrapper the team uses to compare serialized operands.

## Interface
- N, default 8: word length in bits; legal range 2..256.
- IDXW, default 3: width of mis_idx; must satisfy 2^IDXW >= N.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- start  input  1  begins a comparison. Honoured only in IDLE. Bit 0 of both operands is presented in the same cycle.
- b1  input  1  serial operand A, LSB first.
- b2  input  1  serial operand B, LSB first.
- bit_valid  input  1  in SHIFT, marks b1/b2 as holding the next bit pair. Ignored outside SHIFT.
- busy  output  1  high while bits 1..N-1 are still to be consumed.
- done  output  1  one-cycle pulse when the result becomes valid.
- eq  output  1  1 = all N bit pairs equal. Valid from done; held until the next accepted start.
- mis_idx  output  IDXW  index of the lowest mismatching bit. Is 0 when eq=1. Valid and held like eq.

## Operation
- State machine with three states: IDLE, SHIFT and DONE. The reset state is IDLE.
- IDLE:
  - When start=1, sample bit 0: acc <= ~(b1^b2), first <= 0, cnt <= 1, and go to SHIFT.
  - The eq and mis_idx registers reset to 0/0 on start, then track the new word.
  - When start=0, stay in IDLE and hold all outputs.
- SHIFT:
  - When bit_valid=1, evaluate bit cnt:
    - if acc=1 and b1!=b2, record first <= cnt;
    - update acc <= acc & ~(b1^b2);
    - increment cnt.
  - On the valid bit with cnt==N-1, go to DONE.
  - When bit_valid=0, hold all state; this is a stall with no timeout.
  - start is ignored in SHIFT.
- DONE:
  - done=1 for exactly this cycle.
  - eq <= final acc and mis_idx <= first are loaded on the transition into DONE.
  - Unconditionally return to IDLE next cycle. start is ignored in DONE.
- First-mismatch rule: only the lowest-index mismatch is recorded; later mismatches do not change it.
- cnt is $clog2(N)+1 wide internally and never wraps within a word.
- Reset, asserted at any time including mid-word:
  - forces IDLE and aborts the word;
  - busy=0, done=0, eq=0, mis_idx=0;
  - no done pulse is issued for the aborted word.

## Timing
- Reset values: busy=0, done=0, eq=0, mis_idx=0. All outputs are registered.
- Cycle numbering: the cycle where start is sampled high in IDLE is cycle 0.
- With bit_valid held high:
  - bits 1..N-1 are sampled in cycles 1..N-1;
  - busy=1 during cycles 1..N-1;
  - done=1 in cycle N, with eq/mis_idx valid in that same cycle;
  - back in IDLE in cycle N+1, when a new start may be accepted.
- Each cycle with bit_valid=0 in SHIFT delays done by one cycle.
- Minimum start-to-start spacing is N+1 cycles.
- Reset deassertion takes effect on the first rising edge after release; start may be sampled at that edge.

## Test plan
- N=8, A=B=0xA5, bit_valid=1 throughout -> busy high in cycles 1-7, done pulse in cycle 8, eq=1, mis_idx=0.
- N=8, A=0x0C, B=0x00 -> done in cycle 8, eq=0, mis_idx=2 (bit 3 mismatch ignored). Repeat with A=0x80 -> mis_idx=7. Repeat with A=0xA5, B=0xA4 -> mis_idx=0, eq=0.
- Equal words, bit_valid=0 for 3 cycles after bit 4 -> state and cnt hold, done arrives in cycle 11, eq=1.
- start pulsed in cycles 3 and 8 of an active word -> both ignored. Single done in cycle 8, then a start in cycle 9 is accepted and the second word completes in cycle 17.
- Reset asserted asynchronously mid-cycle 4 of a mismatching word -> outputs go to 0 immediately and no done follows. A new equal word after release gives eq=1 and mis_idx=0.
- Back-to-back words (0x00 vs 0xFF, then 0x3C vs 0x3C) -> first done: eq=0, mis_idx=0. eq/mis_idx hold through IDLE until the next start. Second done: eq=1.

Source files
------------

// File: rtl/serial_eq_cmp.sv
// Serial N-bit equality comparator: consumes LSB-first bit pairs and reports
// a registered word-equal flag plus the index of the lowest mismatching bit.
module serial_eq_cmp #(
  parameter int N    = 8,
  parameter int IDXW = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            b1,
  input  logic            b2,
  input  logic            bit_valid,
  output logic            busy,
  output logic            done,
  output logic            eq,
  output logic [IDXW-1:0] mis_idx
);

  localparam int CW = $clog2(N) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic            acc;
  logic [IDXW-1:0] first;
  logic            bit_eq;
  logic            new_mis;

  assign bit_eq  = ~(b1 ^ b2);
  // A mismatch only counts while the word is still fully equal so far.
  assign new_mis = acc & ~bit_eq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= 1'b0;
      first   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      eq      <= 1'b0;
      mis_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            acc     <= bit_eq;
            first   <= '0;
            cnt     <= CW'(1);
            eq      <= 1'b0;
            mis_idx <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_valid) begin
            if (new_mis) first <= IDXW'(cnt);
            acc <= acc & bit_eq;
            cnt <= cnt + 1'b1;
            // Results are loaded from next-state values so the last bit is included.
            if (cnt == CW'(N - 1)) begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              eq      <= acc & bit_eq;
              mis_idx <= new_mis ? IDXW'(cnt) : first;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_eq_cmp.sv
// Self-checking bench for serial_eq_cmp: vector table plus scoreboard queue
// and hand-written sequences for stall, ignored start and mid-word reset.
module tb_serial_eq_cmp;

  localparam int N    = 8;
  localparam int IDXW = 3;

  logic            clk;
  logic            reset;
  logic            start;
  logic            b1;
  logic            b2;
  logic            bit_valid;
  logic            busy;
  logic            done;
  logic            eq;
  logic [IDXW-1:0] mis_idx;

  typedef struct {
    bit eq;
    int idx;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         stall_at;
    int         stall_len;
    bit         glitch;
    bit         exp_eq;
    int         exp_idx;
  } vec_t;

  res_t sb[$];
  vec_t vecs[9];

  int n_checks = 0;
  int n_fail   = 0;
  bit last_eq  = 1'b0;
  int last_idx = 0;

  serial_eq_cmp #(.N(N), .IDXW(IDXW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .b1        (b1),
    .b2        (b2),
    .bit_valid (bit_valid),
    .busy      (busy),
    .done      (done),
    .eq        (eq),
    .mis_idx   (mis_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [7:0] a, input logic [7:0] b);
    res_t r;
    r.eq  = (a == b);
    r.idx = 0;
    for (int i = 7; i >= 0; i--)
      if (a[i] != b[i]) r.idx = i;
    return r;
  endfunction

  // Runs one word; cycle 0 is the cycle in which start is sampled.
  task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b,
                                input int stall_at, input int stall_len,
                                input bit glitch, input res_t exp);
    res_t got;
    int   c;
    bit   seen;
    @(posedge clk); #1;
    start = 1'b1; b1 = a[0]; b2 = b[0]; bit_valid = 1'b0;
    sb.push_back(exp);
    @(negedge clk);
    check_output("idle_busy", busy, 0);
    check_output("idle_done", done, 0);
    check_output("eq_held", eq, last_eq);
    check_output("idx_held", mis_idx, last_idx);
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    for (int i = 1; i < N; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          bit_valid = 1'b0;
          start = glitch && (c == 3);
          @(negedge clk);
          check_output("stall_busy", busy, 1);
          check_output("stall_done", done, 0);
          @(posedge clk); #1;
          c++;
        end
      end
      bit_valid = 1'b1; b1 = a[i]; b2 = b[i];
      start = glitch && (c == 3);
      @(negedge clk);
      check_output("shift_busy", busy, 1);
      check_output("shift_done", done, 0);
      @(posedge clk); #1;
      c++;
    end
    bit_valid = 1'b0;
    start = glitch;
    seen = 1'b0;
    for (int w = 0; w < 4 && !seen; w++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        start = 1'b0;
        c++;
      end
    end
    check_output("done_seen", seen, 1);
    check_output("done_cycle", c, N + stall_len);
    got = sb.pop_front();
    if (seen) begin
      check_output("done_busy", busy, 0);
      check_output("eq", eq, got.eq);
      check_output("mis_idx", mis_idx, got.idx);
    end
    last_eq  = got.eq;
    last_idx = got.idx;
  endtask

  initial begin
    res_t r;
    vecs[0] = '{8'hA5, 8'hA5, 0, 0, 1'b0, 1'b1, 0};
    vecs[1] = '{8'h0C, 8'h00, 0, 0, 1'b0, 1'b0, 2};
    vecs[2] = '{8'h80, 8'h00, 0, 0, 1'b0, 1'b0, 7};
    vecs[3] = '{8'hA5, 8'hA4, 0, 0, 1'b0, 1'b0, 0};
    vecs[4] = '{8'h5A, 8'h5A, 5, 3, 1'b0, 1'b1, 0};
    vecs[5] = '{8'h33, 8'h33, 0, 0, 1'b1, 1'b1, 0};
    vecs[6] = '{8'h12, 8'h16, 0, 0, 1'b0, 1'b0, 2};
    vecs[7] = '{8'h00, 8'hFF, 0, 0, 1'b0, 1'b0, 0};
    vecs[8] = '{8'h3C, 8'h3C, 0, 0, 1'b0, 1'b1, 0};

    reset = 1'b1; start = 1'b0; b1 = 1'b0; b2 = 1'b0; bit_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_eq", eq, 0);
    check_output("rst_idx", mis_idx, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int v = 0; v < 9; v++) begin
      r.eq  = vecs[v].exp_eq;
      r.idx = vecs[v].exp_idx;
      apply_stimulus(vecs[v].a, vecs[v].b, vecs[v].stall_at, vecs[v].stall_len,
                     vecs[v].glitch, r);
    end

    for (int k = 0; k < 6; k++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom_range(0, 255));
      rb = (k % 2 == 0) ? ra : 8'($urandom_range(0, 255));
      apply_stimulus(ra, rb, 0, 0, 1'b0, model(ra, rb));
    end

    // Mid-word reset on a mismatching word: 0x0C vs 0x00.
    @(posedge clk); #1;
    start = 1'b1; b1 = 1'b0; b2 = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i < 4; i++) begin
      bit_valid = 1'b1; b1 = (i == 2 || i == 3); b2 = 1'b0;
      @(posedge clk); #1;
    end
    b1 = 1'b0;
    #3 reset = 1'b1;
    #1;
    check_output("async_busy", busy, 0);
    check_output("async_done", done, 0);
    check_output("async_eq", eq, 0);
    check_output("async_idx", mis_idx, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bit_valid = 1'b1; b1 = 1'($urandom_range(0, 1)); b2 = 1'b0;
      @(negedge clk);
      check_output("post_rst_done", done, 0);
      check_output("post_rst_busy", busy, 0);
      @(posedge clk); #1;
    end
    last_eq = 1'b0;
    last_idx = 0;
    r.eq = 1'b1; r.idx = 0;
    apply_stimulus(8'hC3, 8'hC3, 0, 0, 1'b0, r);

    @(posedge clk); #1;
    @(negedge clk);
    check_output("final_done_low", done, 0);
    check_output("final_eq_held", eq, 1);
    check_output("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
